// File: rtl/shift_ctrl_pkg.sv
// Shared constants and state encoding for the shift-register sequencer.
package shift_ctrl_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNTW  = 5;
    localparam int DEF_DIVW  = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/shift_tick_gen.sv
// Shift-rate prescaler counting 0..div. tick_o looks one cycle ahead so the
// controller can register the shift-enable strobe for the cycle the count hits div.
module shift_tick_gen
    import shift_ctrl_pkg::*;
#(
    parameter int DIVW = DEF_DIVW
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            enable_i,
    input  logic [DIVW-1:0] div_i,
    output logic            tick_o
);

    logic [DIVW-1:0] cnt_q;
    logic [DIVW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = (cnt_q == div_i) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick_o = (cnt_d == div_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Load/shift sequencer for the 16-bit parallel-load shift register.
// state   | meaning
// S_IDLE  | waiting for start; outputs quiet, shift_cnt/sr_in hold last job
// S_LOAD  | single cycle with sr_ld high
// S_SHIFT | issuing n_eff shift pulses, one every div+1 cycles
// S_DONE  | single-cycle done pulse, then back to S_IDLE
module shift_seq_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNTW  = DEF_CNTW,
    parameter int DIVW  = DEF_DIVW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] word_in,
    input  logic [CNTW-1:0]  n_shift,
    input  logic [DIVW-1:0]  div,
    input  logic             abort,
    output logic             sr_ld,
    output logic             sr_shift_en,
    output logic [WIDTH-1:0] sr_in,
    output logic             busy,
    output logic             done,
    output logic [CNTW-1:0]  shift_cnt
);

    localparam logic [CNTW-1:0] N_MAX = CNTW'(WIDTH);

    state_t           state_q;
    logic             sr_ld_q;
    logic             sr_shift_en_q;
    logic [WIDTH-1:0] sr_in_q;
    logic             busy_q;
    logic             done_q;
    logic [CNTW-1:0]  shift_cnt_q;
    logic [CNTW-1:0]  n_eff_q;
    logic [CNTW-1:0]  n_eff_d;
    logic [DIVW-1:0]  div_q;
    logic             in_shift;
    logic             tick;
    logic             last_pulse;

    assign n_eff_d    = (n_shift == '0 || n_shift > N_MAX) ? N_MAX : n_shift;
    assign in_shift   = (state_q == S_SHIFT);
    assign last_pulse = sr_shift_en_q && (shift_cnt_q == n_eff_q);

    shift_tick_gen #(.DIVW(DIVW)) u_tick (
        .clk_i    (clk),
        .rst_ni   (rst),
        .clear_i  (!in_shift),
        .enable_i (in_shift),
        .div_i    (div_q),
        .tick_o   (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            sr_ld_q       <= 1'b0;
            sr_shift_en_q <= 1'b0;
            sr_in_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            shift_cnt_q   <= '0;
            n_eff_q       <= '0;
            div_q         <= '0;
        end else begin
            sr_ld_q       <= 1'b0;
            sr_shift_en_q <= 1'b0;
            done_q        <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sr_in_q     <= word_in;
                        n_eff_q     <= n_eff_d;
                        div_q       <= div;
                        shift_cnt_q <= '0;
                        sr_ld_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_SHIFT;
                        if (tick) begin
                            sr_shift_en_q <= 1'b1;
                            shift_cnt_q   <= shift_cnt_q + 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    // abort wins over a pending pulse and over completion
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (last_pulse) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (tick && shift_cnt_q < n_eff_q) begin
                        sr_shift_en_q <= 1'b1;
                        shift_cnt_q   <= shift_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sr_ld       = sr_ld_q;
    assign sr_shift_en = sr_shift_en_q;
    assign sr_in       = sr_in_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign shift_cnt   = shift_cnt_q;

endmodule
